ctrl_pipeline: RTL and testbench

Carries the decoded control word from ID through EX, MEM and WB, one stage per cycle. It is the consuming end of the main control decoder in the 5-stage RISC-V pipeline. It also owns the control-side hazard logic:
- load-use stall detection;
- branch-taken flush (branch resolved in MEM);
- EX-stage operand forwarding selects.

---
 rtl/riscv_ctrl_pkg.sv | 35 +++
 rtl/ctrl_stage_reg.sv | 21 ++
 rtl/ctrl_pipeline.sv | 117 +++++++++++
 tb/tb_ctrl_pipeline.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RISC-V control path: opcodes, ALUOp, forwarding selects
// and the control-field counts carried by each pipeline stage register.
package riscv_ctrl_pkg;

   typedef enum logic [6:0] {
      OP_RTYPE = 7'b0110011,
      OP_LW    = 7'b0000011,
      OP_SW    = 7'b0100011,
      OP_BEQ   = 7'b1100011
   } opcode_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   // Single-bit controls held per stage (ALUOp, valid and register fields are extra)
   localparam int IDEX_CTRL_BITS  = 6;
   localparam int EXMEM_CTRL_BITS = 5;
   localparam int MEMWB_CTRL_BITS = 2;

   // The younger producer (EX/MEM) wins over MEM/WB when both match
   function automatic logic [1:0] fwd_sel(input logic hit_mem, input logic hit_wb);
      if (hit_mem)
         return FWD_EXMEM;
      else if (hit_wb)
         return FWD_MEMWB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// Generic pipeline stage register: reset/bubble clear to zero, load captures d, else hold.
// One-cycle latency; hold is the only form of backpressure.
module ctrl_stage_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         bubble,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || bubble)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/ctrl_pipeline.sv
// ID->EX->MEM->WB control carrier with load-use stall, MEM-resolved branch flush and
// EX forwarding selects. One stage per cycle; stall holds PC/IF-ID and bubbles ID/EX.
module ctrl_pipeline
   import riscv_ctrl_pkg::*;
#(
   parameter int REG_W   = 5,
   parameter int ALUOP_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic               id_branch,
   input  logic               id_memread,
   input  logic               id_memtoreg,
   input  logic               id_memwrite,
   input  logic               id_alusrc,
   input  logic               id_regwrite,
   input  logic [ALUOP_W-1:0] id_aluop,
   input  logic [REG_W-1:0]   id_rs1,
   input  logic [REG_W-1:0]   id_rs2,
   input  logic [REG_W-1:0]   id_rd,
   input  logic               mem_zero,
   output logic               ex_alusrc,
   output logic [ALUOP_W-1:0] ex_aluop,
   output logic [REG_W-1:0]   ex_rs1,
   output logic [REG_W-1:0]   ex_rs2,
   output logic               mem_memread,
   output logic               mem_memwrite,
   output logic               wb_regwrite,
   output logic               wb_memtoreg,
   output logic [REG_W-1:0]   wb_rd,
   output logic               branch_taken,
   output logic               pc_write,
   output logic               ifid_write,
   output logic               ifid_flush,
   output logic [1:0]         forward_a,
   output logic [1:0]         forward_b
);

   localparam int IDEX_W  = 1 + IDEX_CTRL_BITS + ALUOP_W + 3 * REG_W;
   localparam int EXMEM_W = 1 + EXMEM_CTRL_BITS + REG_W;
   localparam int MEMWB_W = 1 + MEMWB_CTRL_BITS + REG_W;

   logic [IDEX_W-1:0]  idex_q;
   logic [EXMEM_W-1:0] exmem_q;
   logic [MEMWB_W-1:0] memwb_q;

   logic               ex_valid, ex_branch, ex_memread, ex_memtoreg, ex_memwrite;
   logic               ex_alusrc_r, ex_regwrite;
   logic [ALUOP_W-1:0] ex_aluop_r;
   logic [REG_W-1:0]   ex_rd;
   logic               mem_valid, mem_branch, mem_memread_r, mem_memwrite_r;
   logic               mem_memtoreg, mem_regwrite;
   logic [REG_W-1:0]   mem_rd;
   logic               wb_valid, wb_regwrite_r, wb_memtoreg_r;
   logic               stall;
   logic               hit_mem_a, hit_mem_b, hit_wb_a, hit_wb_b;

   assign {ex_valid, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc_r,
           ex_regwrite, ex_aluop_r, ex_rd, ex_rs1, ex_rs2} = idex_q;
   assign {mem_valid, mem_branch, mem_memread_r, mem_memwrite_r, mem_memtoreg,
           mem_regwrite, mem_rd} = exmem_q;
   assign {wb_valid, wb_regwrite_r, wb_memtoreg_r, wb_rd} = memwb_q;

   assign stall = id_valid && ex_valid && ex_memread && (ex_rd != '0) &&
                  ((ex_rd == id_rs1) || (ex_rd == id_rs2));

   assign branch_taken = mem_valid && mem_branch && mem_zero;
   assign ifid_flush   = branch_taken;
   // A taken branch must redirect the PC even if a load-use hazard is also present
   assign pc_write     = !stall || branch_taken;
   assign ifid_write   = pc_write;

   ctrl_stage_reg #(.W(IDEX_W)) u_idex (
      .clk    (clk),
      .rst    (rst),
      .load   (1'b1),
      .bubble (stall || branch_taken || !id_valid),
      .d      ({id_valid, id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc,
                id_regwrite, id_aluop, id_rd, id_rs1, id_rs2}),
      .q      (idex_q)
   );

   ctrl_stage_reg #(.W(EXMEM_W)) u_exmem (
      .clk    (clk),
      .rst    (rst),
      .load   (1'b1),
      .bubble (branch_taken),
      .d      ({ex_valid, ex_branch, ex_memread, ex_memwrite, ex_memtoreg,
                ex_regwrite, ex_rd}),
      .q      (exmem_q)
   );

   ctrl_stage_reg #(.W(MEMWB_W)) u_memwb (
      .clk    (clk),
      .rst    (rst),
      .load   (1'b1),
      .bubble (1'b0),
      .d      ({mem_valid, mem_regwrite, mem_memtoreg, mem_rd}),
      .q      (memwb_q)
   );

   assign hit_mem_a = mem_valid && mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs1);
   assign hit_mem_b = mem_valid && mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs2);
   assign hit_wb_a  = wb_valid && wb_regwrite_r && (wb_rd != '0) && (wb_rd == ex_rs1);
   assign hit_wb_b  = wb_valid && wb_regwrite_r && (wb_rd != '0) && (wb_rd == ex_rs2);
   assign forward_a = fwd_sel(hit_mem_a, hit_wb_a);
   assign forward_b = fwd_sel(hit_mem_b, hit_wb_b);

   assign ex_alusrc    = ex_valid && ex_alusrc_r;
   assign ex_aluop     = ex_aluop_r & {ALUOP_W{ex_valid}};
   assign mem_memread  = mem_valid && mem_memread_r;
   assign mem_memwrite = mem_valid && mem_memwrite_r;
   assign wb_regwrite  = wb_valid && wb_regwrite_r;
   assign wb_memtoreg  = wb_valid && wb_memtoreg_r;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed-vector scoreboard bench for ctrl_pipeline: the driver queues expected
// output values tagged with the cycle they must appear in; a negedge monitor checks them.
module tb_ctrl_pipeline;

   localparam int S_EX_ALUSRC = 0, S_EX_ALUOP = 1, S_EX_RS1 = 2, S_EX_RS2 = 3;
   localparam int S_MEM_MR = 4, S_MEM_MW = 5, S_WB_RW = 6, S_WB_M2R = 7, S_WB_RD = 8;
   localparam int S_BT = 9, S_PCW = 10, S_IFIDW = 11, S_FLUSH = 12, S_FA = 13, S_FB = 14;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc;
   logic       id_regwrite;
   logic [1:0] id_aluop;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       mem_zero;
   logic       ex_alusrc;
   logic [1:0] ex_aluop;
   logic [4:0] ex_rs1, ex_rs2;
   logic       mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg;
   logic [4:0] wb_rd;
   logic       branch_taken, pc_write, ifid_write, ifid_flush;
   logic [1:0] forward_a, forward_b;

   typedef struct {
      int         cyc;
      int         sel;
      logic [7:0] val;
      int         tst;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   tst = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   ctrl_pipeline #(.REG_W(5), .ALUOP_W(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_branch    (id_branch),
      .id_memread   (id_memread),
      .id_memtoreg  (id_memtoreg),
      .id_memwrite  (id_memwrite),
      .id_alusrc    (id_alusrc),
      .id_regwrite  (id_regwrite),
      .id_aluop     (id_aluop),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rd        (id_rd),
      .mem_zero     (mem_zero),
      .ex_alusrc    (ex_alusrc),
      .ex_aluop     (ex_aluop),
      .ex_rs1       (ex_rs1),
      .ex_rs2       (ex_rs2),
      .mem_memread  (mem_memread),
      .mem_memwrite (mem_memwrite),
      .wb_regwrite  (wb_regwrite),
      .wb_memtoreg  (wb_memtoreg),
      .wb_rd        (wb_rd),
      .branch_taken (branch_taken),
      .pc_write     (pc_write),
      .ifid_write   (ifid_write),
      .ifid_flush   (ifid_flush),
      .forward_a    (forward_a),
      .forward_b    (forward_b)
   );

   function automatic logic [7:0] get_sig(input int sel);
      case (sel)
         S_EX_ALUSRC: return {7'd0, ex_alusrc};
         S_EX_ALUOP:  return {6'd0, ex_aluop};
         S_EX_RS1:    return {3'd0, ex_rs1};
         S_EX_RS2:    return {3'd0, ex_rs2};
         S_MEM_MR:    return {7'd0, mem_memread};
         S_MEM_MW:    return {7'd0, mem_memwrite};
         S_WB_RW:     return {7'd0, wb_regwrite};
         S_WB_M2R:    return {7'd0, wb_memtoreg};
         S_WB_RD:     return {3'd0, wb_rd};
         S_BT:        return {7'd0, branch_taken};
         S_PCW:       return {7'd0, pc_write};
         S_IFIDW:     return {7'd0, ifid_write};
         S_FLUSH:     return {7'd0, ifid_flush};
         S_FA:        return {6'd0, forward_a};
         S_FB:        return {6'd0, forward_b};
         default:     return 8'hxx;
      endcase
   endfunction

   function automatic string sig_name(input int sel);
      case (sel)
         S_EX_ALUSRC: return "ex_alusrc";
         S_EX_ALUOP:  return "ex_aluop";
         S_EX_RS1:    return "ex_rs1";
         S_EX_RS2:    return "ex_rs2";
         S_MEM_MR:    return "mem_memread";
         S_MEM_MW:    return "mem_memwrite";
         S_WB_RW:     return "wb_regwrite";
         S_WB_M2R:    return "wb_memtoreg";
         S_WB_RD:     return "wb_rd";
         S_BT:        return "branch_taken";
         S_PCW:       return "pc_write";
         S_IFIDW:     return "ifid_write";
         S_FLUSH:     return "ifid_flush";
         S_FA:        return "forward_a";
         S_FB:        return "forward_b";
         default:     return "unknown";
      endcase
   endfunction

   // Monitor: checks every queued expectation whose cycle tag matches the current window
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            logic [7:0] act;
            act = get_sig(sb[i].sel);
            checks++;
            if (act !== sb[i].val) begin
               failures++;
               $display("FAIL test%0d %s cycle %0d: got %0h expected %0h",
                        sb[i].tst, sig_name(sb[i].sel), cyc, act, sb[i].val);
            end
            sb.delete(i);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic expect_at(input int off, input int sel, input logic [7:0] val);
      exp_t e;
      e.cyc = cyc + off;
      e.sel = sel;
      e.val = val;
      e.tst = tst;
      sb.push_back(e);
   endtask

   task automatic drive(input logic v, br, mr, m2r, mw, as, rw, input logic [1:0] op,
                        input logic [4:0] rd, r1, r2);
      id_valid    = v;
      id_branch   = br;
      id_memread  = mr;
      id_memtoreg = m2r;
      id_memwrite = mw;
      id_alusrc   = as;
      id_regwrite = rw;
      id_aluop    = op;
      id_rd       = rd;
      id_rs1      = r1;
      id_rs2      = r2;
   endtask

   task automatic nop();
      drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0);
   endtask
   task automatic rtype(input logic [4:0] rd, r1, r2);
      drive(1, 0, 0, 0, 0, 0, 1, 2'b10, rd, r1, r2);
   endtask
   task automatic lw(input logic [4:0] rd, r1);
      drive(1, 0, 1, 1, 0, 1, 1, 2'b00, rd, r1, 5'd0);
   endtask
   task automatic sw(input logic [4:0] r1, r2);
      drive(1, 0, 0, 0, 1, 1, 0, 2'b00, 5'd0, r1, r2);
   endtask
   task automatic beq(input logic [4:0] r1, r2);
      drive(1, 1, 0, 0, 0, 0, 0, 2'b01, 5'd0, r1, r2);
   endtask

   initial begin
      rst = 1'b1;
      mem_zero = 1'b0;
      nop();

      // Reset state, then add x3,x1,x2 end to end
      tst = 1;
      tick();
      rst = 1'b0;
      rtype(5'd3, 5'd1, 5'd2);
      expect_at(0, S_PCW, 1);   expect_at(0, S_IFIDW, 1); expect_at(0, S_BT, 0);
      expect_at(0, S_FLUSH, 0); expect_at(0, S_FA, 0);    expect_at(0, S_FB, 0);
      expect_at(0, S_WB_RW, 0); expect_at(0, S_MEM_MR, 0); expect_at(0, S_EX_ALUOP, 0);
      expect_at(1, S_EX_ALUOP, 2); expect_at(1, S_EX_RS1, 1); expect_at(1, S_EX_RS2, 2);
      expect_at(1, S_PCW, 1);
      expect_at(3, S_WB_RW, 1); expect_at(3, S_WB_RD, 3); expect_at(3, S_WB_M2R, 0);
      @(negedge clk);
      checks++;
      if (pc_write !== 1'b1) begin
         failures++;
         $display("FAIL test%0d pc_write after reset: got %0b expected 1", tst, pc_write);
      end
      tick(); nop();
      tick(); tick(); tick();

      // lw x5 then add x6,x5,x7: one stall cycle, bubble, then MEM/WB forward
      tst = 2;
      lw(5'd5, 5'd1);
      tick();
      rtype(5'd6, 5'd5, 5'd7);
      expect_at(0, S_PCW, 0); expect_at(0, S_IFIDW, 0); expect_at(0, S_FLUSH, 0);
      @(negedge clk);
      checks++;
      if (pc_write !== 1'b0) begin
         failures++;
         $display("FAIL test%0d pc_write in stall: got %0b expected 0", tst, pc_write);
      end
      tick();
      rtype(5'd6, 5'd5, 5'd7);
      expect_at(0, S_PCW, 1); expect_at(0, S_MEM_MR, 1); expect_at(0, S_EX_ALUOP, 0);
      tick();
      nop();
      expect_at(0, S_MEM_MR, 0); expect_at(0, S_FA, 1);    expect_at(0, S_FB, 0);
      expect_at(0, S_WB_RD, 5);  expect_at(0, S_WB_M2R, 1); expect_at(0, S_EX_ALUOP, 2);

      // add x4 twice then sub x8,x4,x4: EX/MEM wins over MEM/WB on both operands
      tst = 3;
      tick(); rtype(5'd4, 5'd1, 5'd2);
      tick(); rtype(5'd4, 5'd1, 5'd3);
      tick(); rtype(5'd8, 5'd4, 5'd4);
      expect_at(0, S_FA, 0); expect_at(0, S_FB, 0);
      tick(); nop();
      expect_at(0, S_FA, 2); expect_at(0, S_FB, 2); expect_at(0, S_EX_RS1, 4);
      // MEM/WB-only forward on operand b
      tick(); rtype(5'd11, 5'd1, 5'd2);
      tick(); nop();
      tick(); rtype(5'd12, 5'd1, 5'd11);
      tick(); nop();
      expect_at(0, S_FA, 0); expect_at(0, S_FB, 1);

      // beq taken in MEM flushes a sw in EX and an add in ID
      tst = 4;
      tick(); beq(5'd1, 5'd2);
      tick(); sw(5'd1, 5'd2);
      expect_at(0, S_BT, 0);
      tick(); rtype(5'd13, 5'd1, 5'd2);
      mem_zero = 1'b1;
      expect_at(0, S_BT, 1);     expect_at(0, S_FLUSH, 1); expect_at(0, S_PCW, 1);
      expect_at(0, S_MEM_MW, 0); expect_at(0, S_EX_ALUSRC, 1);
      @(negedge clk);
      checks++;
      if (branch_taken !== 1'b1) begin
         failures++;
         $display("FAIL test%0d branch_taken: got %0b expected 1", tst, branch_taken);
      end
      tick(); nop();
      expect_at(0, S_MEM_MW, 0); expect_at(0, S_EX_ALUOP, 0); expect_at(0, S_WB_RW, 0);
      expect_at(0, S_BT, 0);     expect_at(0, S_FLUSH, 0);
      // beq reaching MEM with zero clear is not taken
      tick(); mem_zero = 1'b0; beq(5'd1, 5'd1);
      tick(); nop();
      tick();
      expect_at(0, S_BT, 0); expect_at(0, S_FLUSH, 0); expect_at(0, S_PCW, 1);

      // lw x0 then use of x0: no stall, no forward
      tst = 5;
      tick(); lw(5'd0, 5'd1);
      tick(); rtype(5'd14, 5'd0, 5'd0);
      expect_at(0, S_PCW, 1); expect_at(0, S_IFIDW, 1);
      tick(); nop();
      expect_at(0, S_FA, 0); expect_at(0, S_FB, 0);

      // load-use and taken branch in the same cycle: flush wins
      tst = 6;
      tick(); beq(5'd1, 5'd2);
      tick(); lw(5'd15, 5'd1);
      tick(); rtype(5'd16, 5'd15, 5'd1);
      mem_zero = 1'b1;
      expect_at(0, S_PCW, 1); expect_at(0, S_IFIDW, 1); expect_at(0, S_FLUSH, 1);
      tick(); nop();
      mem_zero = 1'b0;
      expect_at(0, S_MEM_MR, 0); expect_at(0, S_EX_ALUOP, 0);

      // reset asserted during a stall
      tst = 7;
      tick(); lw(5'd17, 5'd1);
      tick(); rtype(5'd18, 5'd17, 5'd0);
      expect_at(0, S_PCW, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      expect_at(0, S_PCW, 1);   expect_at(0, S_IFIDW, 1); expect_at(0, S_MEM_MR, 0);
      expect_at(0, S_WB_RW, 0); expect_at(0, S_WB_RD, 0); expect_at(0, S_FA, 0);
      expect_at(0, S_EX_ALUOP, 0); expect_at(0, S_BT, 0);
      @(negedge clk);
      checks++;
      if (pc_write !== 1'b1) begin
         failures++;
         $display("FAIL test%0d pc_write after mid-stall reset: got %0b expected 1",
                  tst, pc_write);
      end
      tick(); nop();
      tick(); tick(); tick();

      foreach (sb[i]) begin
         checks++;
         failures++;
         $display("FAIL test%0d %s never checked: expected %0h at cycle %0d",
                  sb[i].tst, sig_name(sb[i].sel), sb[i].val, sb[i].cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
